// File: rtl/iterative_divider_pkg.sv
// Shared constants for the iterative divider: FSM encoding and fixed result patterns.
package iterative_divider_pkg;

  // FSM state encoding (kept as plain constants for legacy tool flows)
  localparam logic [1:0] DIV_IDLE    = 2'd0;
  localparam logic [1:0] DIV_BUSY    = 2'd1;
  localparam logic [1:0] DIV_FIX     = 2'd2;
  localparam logic [1:0] DIV_SPECIAL = 2'd3;

  // Widest operand the constants below cover; users slice [WIDTH-1:0]
  localparam int DIV_MAX_WIDTH = 64;

  // Quotient returned for a zero divisor: all ones at any width
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/iterative_divider_if.sv
// Request/response bundle between pipeline control and the iterative divider.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_division;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;

  // Requester side (pipeline control / testbench)
  modport master (
    output start_division, is_signed, dividend, divisor,
    input  quotient, remainder, busy, done
  );

  // Divider side
  modport slave (
    input  start_division, is_signed, dividend, divisor,
    output quotient, remainder, busy, done
  );
endinterface

// File: rtl/iterative_divider_division_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it is non-negative.
module iterative_divider_division_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  // One extra bit beyond the shifted remainder holds the borrow of the trial subtract
  logic [WIDTH+1:0] w_trial;
  logic             w_neg;

  assign w_trial = {i_rem, i_bit} - {2'b00, i_dsr};
  assign w_neg   = w_trial[WIDTH+1];

  // Restore the shifted remainder when the subtraction went negative
  always_comb begin
    o_qbit = ~w_neg;
    o_rem  = w_trial[WIDTH:0];
    if (w_neg) begin
      o_rem = {i_rem[WIDTH-1:0], i_bit};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle integer divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Magnitudes are divided one bit per clock; signs are re-applied in a final fix-up cycle.
// Divide-by-zero and signed overflow bypass the loop and answer in one cycle.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic         clock,
  input  logic         reset,
  iterative_divider_if.slave div_if
);

  localparam logic [WIDTH-1:0]       W_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  // Absolute value for signed operands, pass-through for unsigned ones
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  // Two's-complement negation applied only when the recorded sign asks for it
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic en);
    return en ? -v : v;
  endfunction

  // Control state
  logic [1:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_done;
  logic [WIDTH-1:0]       r_quotient;
  logic [WIDTH-1:0]       r_remainder;

  // Datapath state; r_dvd starts as the dividend magnitude and fills with quotient bits
  logic [WIDTH:0]         r_rem;
  logic [WIDTH-1:0]       r_dvd;
  logic [WIDTH-1:0]       r_dsr;
  logic [WIDTH-1:0]       r_dividend_orig;
  logic                   r_q_neg;
  logic                   r_r_neg;
  logic                   r_div_zero;

  logic signed [WIDTH-1:0] w_dvd_s;
  logic signed [WIDTH-1:0] w_dsr_s;
  logic                    w_dvd_neg;
  logic                    w_dsr_neg;
  logic                    w_div_zero;
  logic                    w_overflow;
  logic                    w_start;
  logic [WIDTH:0]          w_rem_next;
  logic                    w_qbit;

  assign w_dvd_s    = div_if.dividend;
  assign w_dsr_s    = div_if.divisor;
  assign w_dvd_neg  = div_if.is_signed & w_dvd_s[WIDTH-1];
  assign w_dsr_neg  = div_if.is_signed & w_dsr_s[WIDTH-1];
  assign w_div_zero = (div_if.divisor == '0);
  assign w_overflow = div_if.is_signed && (div_if.dividend == W_MIN) && (div_if.divisor == '1);
  assign w_start    = div_if.start_division && (r_state == DIV_IDLE);

  iterative_divider_division_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  assign div_if.busy      = (r_state != DIV_IDLE);
  assign div_if.done      = r_done;
  assign div_if.quotient  = r_quotient;
  assign div_if.remainder = r_remainder;

  // FSM, iteration counter and registered results; reset abandons any in-flight operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= DIV_IDLE;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (w_start) begin
            r_count <= '0;
            r_state <= (w_div_zero || w_overflow) ? DIV_SPECIAL : DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          r_count <= r_count + CNT_ONE;
          if (r_count == CNT_LAST) begin
            r_state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_quotient  <= apply_sign(r_dvd, r_q_neg);
          r_remainder <= apply_sign(r_rem[WIDTH-1:0], r_r_neg);
          r_done      <= 1'b1;
          r_state     <= DIV_IDLE;
        end
        DIV_SPECIAL: begin
          if (r_div_zero) begin
            r_quotient  <= DIV_ZERO_QUOT[WIDTH-1:0];
            r_remainder <= r_dividend_orig;
          end else begin
            r_quotient  <= W_MIN;
            r_remainder <= '0;
          end
          r_done  <= 1'b1;
          r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  // Operand capture and the shift/subtract loop; contents are don't-care until a start
  always_ff @(posedge clock) begin
    case (r_state)
      DIV_IDLE: begin
        if (w_start) begin
          r_rem           <= '0;
          r_dvd           <= magnitude(w_dvd_s, div_if.is_signed);
          r_dsr           <= magnitude(w_dsr_s, div_if.is_signed);
          r_q_neg         <= w_dvd_neg ^ w_dsr_neg;
          r_r_neg         <= w_dvd_neg;
          r_dividend_orig <= div_if.dividend;
          r_div_zero      <= w_div_zero;
        end
      end
      DIV_BUSY: begin
        r_rem <= w_rem_next;
        r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed testbench for iterative_divider (WIDTH = 32) with hand-computed results.
module tb_iterative_divider;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  iterative_divider_if #(.WIDTH(32)) dif ();

  iterative_divider #(
    .WIDTH       (32),
    .COUNT_WIDTH (6)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .div_if (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present a request in the current cycle; returns 1 ns after the accepting edge T
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.start_division = 1'b1;
    dif.is_signed      = sgn;
    dif.dividend       = a;
    dif.divisor        = b;
    @(posedge clock);
    #1;
    dif.start_division = 1'b0;
  endtask

  // Count edges after T until done, bounded; base = edges already elapsed since T
  task automatic wait_done(input string tag, input int base, input int exp_lat);
    int lat;
    lat = base;
    while (dif.done !== 1'b1 && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy_at_done"}, {31'b0, dif.busy}, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int elat);
    issue(sgn, a, b);
    check_val({tag, "_busy"}, {31'b0, dif.busy}, 32'd1);
    wait_done(tag, 0, elat);
    check_val({tag, "_q"}, dif.quotient, eq);
    check_val({tag, "_r"}, dif.remainder, er);
  endtask

  initial begin
    reset              = 1'b1;
    dif.start_division = 1'b0;
    dif.is_signed      = 1'b0;
    dif.dividend       = '0;
    dif.divisor        = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_busy", {31'b0, dif.busy}, 32'd0);
    check_val("rst_done", {31'b0, dif.done}, 32'd0);
    check_val("rst_q", dif.quotient, 32'd0);
    check_val("rst_r", dif.remainder, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33);
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33);
    run_div("s_m7_m2",  1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   33);
    run_div("u_div0",   1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1);
    run_div("s_div0",   1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1);
    run_div("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1);
    run_div("u_ovf",    1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33);
    run_div("zero_num", 1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          33);
    run_div("by_one",   1'b1, 32'hFFFFFFF7,   32'd1,          32'hFFFFFFF7,   32'd0,          33);
    run_div("u_big",    0,    32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          33);
    run_div("u_min_3",  1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          33);

    // A start pulse and operand changes while busy must not disturb 100 / 7
    issue(1'b0, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    dif.start_division = 1'b1;
    dif.dividend       = 32'd9;
    dif.divisor        = 32'd3;
    @(posedge clock);
    #1;
    dif.start_division = 1'b0;
    dif.dividend       = 32'd0;
    dif.divisor        = 32'd0;
    wait_done("ignore", 6, 33);
    check_val("ignore_q", dif.quotient, 32'd14);
    check_val("ignore_r", dif.remainder, 32'd2);

    // Start presented in the done cycle is taken immediately
    issue(1'b0, 32'd9, 32'd3);
    check_val("b2b_done_pulse", {31'b0, dif.done}, 32'd0);
    check_val("b2b_busy", {31'b0, dif.busy}, 32'd1);
    wait_done("b2b", 0, 33);
    check_val("b2b_q", dif.quotient, 32'd3);
    check_val("b2b_r", dif.remainder, 32'd0);

    // Asynchronous reset in the middle of an operation
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    check_val("hold_q", dif.quotient, 32'd3);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_busy", {31'b0, dif.busy}, 32'd0);
    check_val("arst_done", {31'b0, dif.done}, 32'd0);
    check_val("arst_q", dif.quotient, 32'd0);
    check_val("arst_r", dif.remainder, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_div("after_rst", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
